// File: rtl/sb_spi_bus_master_if.sv
// Command/response handshake and SPI-block system-bus signals for sb_spi_bus_master.
// The master modport is the bus master's view; the slave modport is the peer side.
interface sb_spi_bus_master_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_timeout;
    logic       sb_stb;
    logic       sb_rw;
    logic [7:0] sb_adr;
    logic [7:0] sb_dat_o;
    logic [7:0] sb_dat_i;
    logic       sb_ack;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, sb_dat_i, sb_ack,
        output req_ready, rsp_valid, rsp_rdata, rsp_timeout, sb_stb, sb_rw, sb_adr, sb_dat_o
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, sb_dat_i, sb_ack,
        input  req_ready, rsp_valid, rsp_rdata, rsp_timeout, sb_stb, sb_rw, sb_adr, sb_dat_o
    );
endinterface

// File: rtl/sb_spi_bus_master.sv
// Single-outstanding register-access master for the hard SPI block system bus:
// one strobe per command, bounded wait for acknowledge, one response per command.
module sb_spi_bus_master #(
    parameter logic [3:0]  BUS_ADDR74     = 4'b0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    sb_spi_bus_master_if.master         bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_RESP   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_r, state_s;
    logic [7:0] cnt_r, cnt_s;
    logic       req_ready_r, req_ready_s;
    logic       rsp_valid_r, rsp_valid_s;
    logic [7:0] rsp_rdata_r, rsp_rdata_s;
    logic       rsp_timeout_r, rsp_timeout_s;
    logic       sb_stb_r, sb_stb_s;
    logic       sb_rw_r, sb_rw_s;
    logic [7:0] sb_adr_r, sb_adr_s;
    logic [7:0] sb_dat_o_r, sb_dat_o_s;
    logic       accept_s;
    logic       expire_s;

    assign accept_s = (state_r == ST_IDLE) && bus.req_valid && req_ready_r;
    assign expire_s = (cnt_r == CNT_LAST);

    // State and registered-output flops; reset clears the transfer asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 8'd0;
            req_ready_r   <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= 8'h00;
            rsp_timeout_r <= 1'b0;
            sb_stb_r      <= 1'b0;
            sb_rw_r       <= 1'b0;
            sb_adr_r      <= 8'h00;
            sb_dat_o_r    <= 8'h00;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            req_ready_r   <= req_ready_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_rdata_r   <= rsp_rdata_s;
            rsp_timeout_r <= rsp_timeout_s;
            sb_stb_r      <= sb_stb_s;
            sb_rw_r       <= sb_rw_s;
            sb_adr_r      <= sb_adr_s;
            sb_dat_o_r    <= sb_dat_o_s;
        end
    end

    // Next-state decode; an acknowledge in the final counted cycle still ends in success.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_STROBE;
                else          state_s = ST_IDLE;
            end
            ST_STROBE: begin
                if (bus.sb_ack || expire_s) state_s = ST_RESP;
                else                        state_s = ST_STROBE;
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_s = ST_GAP;
                else               state_s = ST_RESP;
            end
            ST_GAP:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and the strobe-cycle counter.
    always_comb begin
        cnt_s         = cnt_r;
        rsp_valid_s   = rsp_valid_r;
        rsp_rdata_s   = rsp_rdata_r;
        rsp_timeout_s = rsp_timeout_r;
        sb_stb_s      = sb_stb_r;
        sb_rw_s       = sb_rw_r;
        sb_adr_s      = sb_adr_r;
        sb_dat_o_s    = sb_dat_o_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_s      = 8'd0;
                    sb_stb_s   = 1'b1;
                    sb_rw_s    = bus.req_write;
                    sb_adr_s   = {BUS_ADDR74, bus.req_addr};
                    sb_dat_o_s = bus.req_write ? bus.req_wdata : 8'h00;
                end else begin
                    sb_stb_s   = 1'b0;
                end
            end
            ST_STROBE: begin
                if (bus.sb_ack) begin
                    sb_stb_s      = 1'b0;
                    rsp_valid_s   = 1'b1;
                    rsp_rdata_s   = sb_rw_r ? 8'h00 : bus.sb_dat_i;
                    rsp_timeout_s = 1'b0;
                end else if (expire_s) begin
                    sb_stb_s      = 1'b0;
                    rsp_valid_s   = 1'b1;
                    rsp_rdata_s   = 8'h00;
                    rsp_timeout_s = 1'b1;
                end else begin
                    cnt_s         = cnt_r + 8'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) rsp_valid_s = 1'b0;
                else               rsp_valid_s = 1'b1;
            end
            ST_GAP: begin
                sb_stb_s    = 1'b0;
                rsp_valid_s = 1'b0;
            end
            default: begin
                sb_stb_s    = 1'b0;
                rsp_valid_s = 1'b0;
            end
        endcase
        req_ready_s = (state_s == ST_IDLE);
    end

    assign bus.req_ready   = req_ready_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_rdata   = rsp_rdata_r;
    assign bus.rsp_timeout = rsp_timeout_r;
    assign bus.sb_stb      = sb_stb_r;
    assign bus.sb_rw       = sb_rw_r;
    assign bus.sb_adr      = sb_adr_r;
    assign bus.sb_dat_o    = sb_dat_o_r;

endmodule

// File: tb/tb_sb_spi_bus_master.sv
// Self-checking bench for sb_spi_bus_master: two instances (upper nibble 0 and 1) see
// identical stimulus; expected responses and strobe lengths come from command-level rules.
module tb_sb_spi_bus_master;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [3:0] req_addr = 4'h0;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_ready = 1'b0;
    logic [7:0] sb_dat_i = 8'h00;
    logic       sb_ack = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    sb_spi_bus_master_if if0 ();
    sb_spi_bus_master_if if1 ();

    assign if0.req_valid = req_valid;
    assign if0.req_write = req_write;
    assign if0.req_addr  = req_addr;
    assign if0.req_wdata = req_wdata;
    assign if0.rsp_ready = rsp_ready;
    assign if0.sb_dat_i  = sb_dat_i;
    assign if0.sb_ack    = sb_ack;
    assign if1.req_valid = req_valid;
    assign if1.req_write = req_write;
    assign if1.req_addr  = req_addr;
    assign if1.req_wdata = req_wdata;
    assign if1.rsp_ready = rsp_ready;
    assign if1.sb_dat_i  = sb_dat_i;
    assign if1.sb_ack    = sb_ack;

    sb_spi_bus_master #(.BUS_ADDR74(4'h0), .TIMEOUT_CYCLES(T)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0));
    sb_spi_bus_master #(.BUS_ADDR74(4'h1), .TIMEOUT_CYCLES(T)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_both(input string tag, input logic [31:0] obs0, input logic [31:0] obs1,
                            input logic [31:0] exp);
        chk({"d0_", tag}, obs0, exp);
        chk({"d1_", tag}, obs1, exp);
    endtask

    // One command; ack_delay = strobe cycles before ack (negative = never).
    task automatic do_cmd(input logic wr, input logic [3:0] addr, input logic [7:0] wdata,
                          input logic [7:0] rdsrc, input int ack_delay, input int rsp_delay);
        bit         acked;
        int         exp_cycles;
        int         cycles;
        logic [7:0] exp_rdata;
        logic       exp_to;
        acked      = (ack_delay >= 0) && (ack_delay < T);
        exp_cycles = acked ? ack_delay + 1 : T;
        exp_rdata  = (acked && !wr) ? rdsrc : 8'h00;
        exp_to     = !acked;

        for (int i = 0; i < 8 && !if1.req_ready; i++) @(negedge clk);
        chk("ready_wait", if1.req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_wdata = $urandom_range(0, 255);
        @(negedge clk);
        cycles = 0;
        while (if1.sb_stb && cycles < T + 4) begin
            chk("adr0", if0.sb_adr, {4'h0, addr});
            chk("adr1", if1.sb_adr, {4'h1, addr});
            chk_both("rw", if0.sb_rw, if1.sb_rw, wr);
            chk_both("dat_o", if0.sb_dat_o, if1.sb_dat_o, wr ? wdata : 8'h00);
            chk_both("rdy_strobe", if0.req_ready, if1.req_ready, 1'b0);
            sb_ack   = (cycles == ack_delay);
            sb_dat_i = sb_ack ? rdsrc : 8'($urandom_range(0, 255));
            cycles++;
            @(negedge clk);
            sb_ack = 1'b0;
        end
        chk("stb_cycles", cycles, exp_cycles);
        chk_both("stb_low", if0.sb_stb, if1.sb_stb, 1'b0);
        chk_both("rsp_valid", if0.rsp_valid, if1.rsp_valid, 1'b1);
        chk_both("rsp_rdata", if0.rsp_rdata, if1.rsp_rdata, exp_rdata);
        chk_both("rsp_timeout", if0.rsp_timeout, if1.rsp_timeout, exp_to);
        for (int i = 0; i < rsp_delay; i++) begin
            sb_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk_both("rsp_hold_v", if0.rsp_valid, if1.rsp_valid, 1'b1);
            chk_both("rsp_hold_d", if0.rsp_rdata, if1.rsp_rdata, exp_rdata);
            chk_both("rsp_hold_t", if0.rsp_timeout, if1.rsp_timeout, exp_to);
            chk_both("stb_resp", if0.sb_stb, if1.sb_stb, 1'b0);
        end
        sb_ack    = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk_both("gap_valid", if0.rsp_valid, if1.rsp_valid, 1'b0);
        chk_both("gap_ready", if0.req_ready, if1.req_ready, 1'b0);
        chk_both("gap_stb", if0.sb_stb, if1.sb_stb, 1'b0);
        @(negedge clk);
        chk_both("idle_ready", if0.req_ready, if1.req_ready, 1'b1);
    endtask

    initial begin
        int acc[$];
        bit hist[$];
        int lows;

        // Reset state
        #12;
        chk_both("rst_ready", if0.req_ready, if1.req_ready, 1'b0);
        chk_both("rst_valid", if0.rsp_valid, if1.rsp_valid, 1'b0);
        chk_both("rst_to", if0.rsp_timeout, if1.rsp_timeout, 1'b0);
        chk_both("rst_rdata", if0.rsp_rdata, if1.rsp_rdata, 8'h00);
        chk_both("rst_stb", if0.sb_stb, if1.sb_stb, 1'b0);
        chk_both("rst_rw", if0.sb_rw, if1.sb_rw, 1'b0);
        chk_both("rst_adr", if0.sb_adr, if1.sb_adr, 8'h00);
        chk_both("rst_dat", if0.sb_dat_o, if1.sb_dat_o, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk_both("pre_edge_ready", if0.req_ready, if1.req_ready, 1'b0);
        @(posedge clk);
        #1 chk_both("first_edge_ready", if0.req_ready, if1.req_ready, 1'b1);
        @(negedge clk);

        // Directed: write with delayed ack, read, full timeout, ack on final cycle
        do_cmd(1'b1, 4'h9, 8'hA5, 8'h00, 2, 1);
        do_cmd(1'b0, 4'hE, 8'h77, 8'h3C, 0, 0);
        do_cmd(1'b0, 4'h2, 8'h00, 8'h5A, -1, 2);
        do_cmd(1'b0, 4'h7, 8'h00, 8'hC3, T - 1, 0);
        do_cmd(1'b1, 4'h0, 8'hFF, 8'h00, T, 0);

        // Randomized commands
        for (int k = 0; k < 24; k++) begin
            do_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                   8'($urandom_range(0, 255)), $urandom_range(0, T + 2), $urandom_range(0, 3));
        end

        // Back-to-back with rsp_ready tied high and ack following strobe
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'h3;
        req_wdata = 8'h11;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            sb_ack = if1.sb_stb;
            if (acc.size() == 2) req_valid = 1'b0;
            if (req_valid && if1.req_ready) acc.push_back(n);
            hist.push_back(if1.sb_stb);
        end
        sb_ack    = 1'b0;
        rsp_ready = 1'b0;
        chk("b2b_accepts", acc.size(), 2);
        if (acc.size() == 2) begin
            chk("b2b_period", acc[1] - acc[0], 4);
            chk("b2b_stb1", hist[acc[0] + 1], 1'b1);
            chk("b2b_stb2", hist[acc[1] + 1], 1'b1);
            lows = 0;
            for (int i = acc[0] + 2; i <= acc[1]; i++) lows += (hist[i] == 1'b0) ? 1 : 0;
            chk("b2b_gap", (lows >= 1), 1'b1);
        end
        @(negedge clk);

        // Reset asserted mid-strobe
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'h5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk_both("mid_stb_high", if0.sb_stb, if1.sb_stb, 1'b1);
        #2 reset_n = 1'b0;
        #1 chk_both("async_stb", if0.sb_stb, if1.sb_stb, 1'b0);
        chk_both("async_ready", if0.req_ready, if1.req_ready, 1'b0);
        chk_both("async_valid", if0.rsp_valid, if1.rsp_valid, 1'b0);
        sb_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sb_ack  = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1 chk_both("rel_ready", if0.req_ready, if1.req_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_both("post_rst_valid", if0.rsp_valid, if1.rsp_valid, 1'b0);
            chk_both("post_rst_stb", if0.sb_stb, if1.sb_stb, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sb_spi_bus_master.md
SB_SPI_BUS_MASTER -- requirements
Module: sb_spi_bus_master

Interface
REQ-001 Parameter BUS_ADDR74, default 4'b0000: upper address nibble selecting the hard SPI block on the system bus.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, range 2..255: strobe cycles allowed before a transfer is abandoned.
REQ-003 clk  input  1  single clock, rising edge; also drives SBCLKI of the SPI block.
REQ-004 reset_n  input  1  reset; asynchronous assert, active-low.
REQ-005 req_valid  input  1  command request.
REQ-006 req_ready  output  1  command accepted when req_valid and req_ready are both high on a clk edge.
REQ-007 req_write  input  1  1 = register write, 0 = register read.
REQ-008 req_addr  input  4  register offset (SBADRI3..0).
REQ-009 req_wdata  input  8  write data.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-012 rsp_rdata  output  8  read data; 0 for writes and timeouts.
REQ-013 rsp_timeout  output  1  transfer ended without acknowledge.
REQ-014 sb_stb  output  1  to SBSTBI.
REQ-015 sb_rw  output  1  to SBRWI; 1 = write.
REQ-016 sb_adr  output  8  to SBADRI7..0.
REQ-017 sb_dat_o  output  8  to SBDATI7..0.
REQ-018 sb_dat_i  input  8  from SBDATO7..0.
REQ-019 sb_ack  input  1  from SBACKO.

Function
REQ-020 FSM states: IDLE, STROBE, RESP, GAP; reset state IDLE.
REQ-021 IDLE: req_ready=1; on accept, register write/addr/wdata and enter STROBE on the next edge.
REQ-022 Entering STROBE: sb_stb=1, sb_rw=req_write, sb_adr={BUS_ADDR74,req_addr}, sb_dat_o=req_wdata (0 for reads); all four hold stable until STROBE exits.
REQ-023 STROBE: timeout counter starts at 0 and increments each cycle sb_ack is low.
REQ-024 sb_ack high in STROBE: capture sb_dat_i into rsp_rdata for reads (0 for writes), set rsp_timeout=0, drop sb_stb, enter RESP on the same edge.
REQ-025 Counter reaching TIMEOUT_CYCLES-1 with sb_ack low: rsp_rdata=0, rsp_timeout=1, drop sb_stb, enter RESP.
REQ-026 sb_ack high on the same cycle the counter expires: treated as success (REQ-024 wins).
REQ-027 RESP: rsp_valid=1; rsp_rdata and rsp_timeout hold until the handshake; on handshake enter GAP.
REQ-028 GAP: exactly one cycle with sb_stb=0 and req_ready=0, then IDLE, so back-to-back commands are separated by at least one strobe-low cycle.
REQ-029 req_ready=0 in STROBE, RESP and GAP; requests are not queued.
REQ-030 sb_ack high outside STROBE is ignored.
REQ-031 Minimum command-to-command period with immediate ack and rsp_ready tied high: 4 cycles (accept, STROBE, RESP, GAP).

Reset
REQ-032 While reset_n is low: state IDLE, req_ready=0, rsp_valid=0, rsp_timeout=0, rsp_rdata=0, sb_stb=0, sb_rw=0, sb_adr=0, sb_dat_o=0, counter=0.
REQ-033 req_ready rises on the first clk edge after reset_n deasserts.
REQ-034 Reset asserted mid-transfer drops sb_stb immediately (asynchronously) and discards the transfer; no response is produced.

Verification
REQ-035 Write: req write, addr 4'h9, data 8'hA5, BUS_ADDR74=4'h0; ack 2 cycles after strobe -> sb_adr=8'h09, sb_dat_o=8'hA5, sb_rw=1 held until ack, rsp_valid with rdata=0, timeout=0.
REQ-036 Read: addr 4'hE, BUS_ADDR74=4'h1; ack with sb_dat_i=8'h3C -> sb_adr=8'h1E, sb_rw=0, rsp_rdata=8'h3C, timeout=0.
REQ-037 Timeout: TIMEOUT_CYCLES=16, ack never asserted -> sb_stb high exactly 16 cycles, then rsp_timeout=1, rsp_rdata=0.
REQ-038 Ack coincides with last timeout cycle -> success response, timeout=0.
REQ-039 Back-to-back: two commands, rsp_ready tied 1, immediate ack -> sb_stb low for at least one cycle between strobes; second accept 4 cycles after the first.
REQ-040 Reset in STROBE: reset_n low mid-strobe -> sb_stb=0 without a clk edge, rsp_valid never asserted, req_ready=1 one edge after release.
